// File: rtl/segre_pkg.sv
// Shared Segre core types: memory-op data sizes and the load/store unit FSM states.
package segre_pkg;

    typedef enum logic [1:0] {
        BYTE = 2'b00,
        HALF = 2'b01,
        WORD = 2'b10
    } memop_data_type_e;

    typedef enum logic [2:0] {
        LSU_IDLE,
        LSU_REQ0,
        LSU_WAIT0,
        LSU_REQ1,
        LSU_WAIT1,
        LSU_RESP
    } lsu_state_e;

    function automatic logic [2:0] memop_size_bytes(input memop_data_type_e t);
        case (t)
            BYTE:    return 3'd1;
            HALF:    return 3'd2;
            WORD:    return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

endpackage

// File: rtl/segre_lsu_rdata_ext.sv
// Load data path: merges the two bus beats, shifts the addressed bytes down to lane 0
// and sign- or zero-extends them to 32 bits.
module segre_lsu_rdata_ext
    import segre_pkg::*;
#(
    parameter int unsigned DATA_W = 32
) (
    input  logic [DATA_W-1:0]          beat0_i,
    input  logic [DATA_W-1:0]          beat1_i,
    input  logic [$clog2(DATA_W/8)-1:0] off_i,
    input  memop_data_type_e           type_i,
    input  logic                       unsigned_i,
    output logic [31:0]                rdata_o
);

    logic [31:0] raw;

    // Second beat sits above the first, so a crossing access is one contiguous shift.
    assign raw = 32'({beat1_i, beat0_i} >> {off_i, 3'b000});

    always_comb begin
        rdata_o = raw;
        case (type_i)
            BYTE:    rdata_o = unsigned_i ? {24'h0, raw[7:0]} : {{24{raw[7]}}, raw[7:0]};
            HALF:    rdata_o = unsigned_i ? {16'h0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
            default: rdata_o = raw;
        endcase
    end

endmodule

// File: rtl/segre_lsu.sv
// Segre load/store unit: one BYTE/HALF/WORD access at a time onto a DATA_W-wide bus.
// Define SEGRE_LSU_MISALIGNED_EN to split bus-crossing accesses; otherwise they are rejected.
module segre_lsu
    import segre_pkg::*;
#(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned ADDR_SIZE = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_store_i,
    input  logic [1:0]             req_type_i,
    input  logic                   req_unsigned_i,
    input  logic [ADDR_SIZE-1:0]   req_addr_i,
    input  logic [31:0]            req_wdata_i,
    output logic                   rsp_valid_o,
    output logic [31:0]            rsp_rdata_o,
    output logic                   rsp_err_o,
    output logic                   mem_req_o,
    output logic                   mem_we_o,
    output logic [ADDR_SIZE-1:0]   mem_addr_o,
    output logic [DATA_W/8-1:0]    mem_be_o,
    output logic [DATA_W-1:0]      mem_wdata_o,
    input  logic                   mem_gnt_i,
    input  logic                   mem_rvalid_i,
    input  logic [DATA_W-1:0]      mem_rdata_i
);

    localparam int unsigned B  = DATA_W / 8;
    localparam int unsigned OW = $clog2(B);

    lsu_state_e           state_q, state_d;
    logic                 store_q, unsigned_q, cross_q;
    memop_data_type_e     type_q;
    logic [ADDR_SIZE-1:0] addr_q;
    logic [31:0]          wdata_q;
    logic [DATA_W-1:0]    beat0_q, beat1_q;

    memop_data_type_e     req_type;
    logic [OW-1:0]        off_q;
    logic                 req_cross, handshake, hi_beat, in_resp;
    logic [2*B-1:0]       be_mask, be_full;
    logic [2*DATA_W-1:0]  wdata_full;
    logic [31:0]          ext_rdata;

    assign req_type    = memop_data_type_e'(req_type_i);
    assign req_cross   = ({{(32-OW){1'b0}}, req_addr_i[OW-1:0]} + 32'(memop_size_bytes(req_type)))
                         > 32'(B);
    assign req_ready_o = !rst_i && (state_q == LSU_IDLE);
    assign handshake   = req_valid_i && req_ready_o;
    assign off_q       = addr_q[OW-1:0];

    always_comb begin
        state_d = state_q;
        case (state_q)
            LSU_IDLE: begin
                if (handshake) begin
`ifdef SEGRE_LSU_MISALIGNED_EN
                    state_d = LSU_REQ0;
`else
                    state_d = req_cross ? LSU_RESP : LSU_REQ0;
`endif
                end
            end
            LSU_REQ0:  if (mem_gnt_i) state_d = LSU_WAIT0;
            LSU_WAIT0: begin
                if (mem_rvalid_i) begin
`ifdef SEGRE_LSU_MISALIGNED_EN
                    state_d = cross_q ? LSU_REQ1 : LSU_RESP;
`else
                    state_d = LSU_RESP;
`endif
                end
            end
`ifdef SEGRE_LSU_MISALIGNED_EN
            LSU_REQ1:  if (mem_gnt_i) state_d = LSU_WAIT1;
            LSU_WAIT1: if (mem_rvalid_i) state_d = LSU_RESP;
`endif
            LSU_RESP:  state_d = LSU_IDLE;
            default:   state_d = LSU_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= LSU_IDLE;
            store_q    <= 1'b0;
            unsigned_q <= 1'b0;
            cross_q    <= 1'b0;
            type_q     <= BYTE;
            addr_q     <= '0;
            wdata_q    <= '0;
            beat0_q    <= '0;
            beat1_q    <= '0;
        end else begin
            state_q <= state_d;
            if (handshake) begin
                store_q    <= req_store_i;
                unsigned_q <= req_unsigned_i;
                cross_q    <= req_cross;
                type_q     <= req_type;
                addr_q     <= req_addr_i;
                wdata_q    <= req_wdata_i;
                beat0_q    <= '0;
                beat1_q    <= '0;
            end
            if (state_q == LSU_WAIT0 && mem_rvalid_i) beat0_q <= mem_rdata_i;
`ifdef SEGRE_LSU_MISALIGNED_EN
            if (state_q == LSU_WAIT1 && mem_rvalid_i) beat1_q <= mem_rdata_i;
`endif
        end
    end

    // Enables and data are built over two bus words; the upper half feeds the second beat.
    always_comb begin
        be_mask = '0;
        case (type_q)
            BYTE:    be_mask[0]   = 1'b1;
            HALF:    be_mask[1:0] = 2'b11;
            WORD:    be_mask[3:0] = 4'b1111;
            default: be_mask      = '0;
        endcase
    end

    assign be_full    = be_mask << off_q;
    assign wdata_full = {{(2*DATA_W-32){1'b0}}, wdata_q} << {off_q, 3'b000};
    assign hi_beat    = (state_q == LSU_REQ1);

    assign mem_req_o   = !rst_i && (state_q == LSU_REQ0 || hi_beat);
    assign mem_we_o    = mem_req_o && store_q;
    assign mem_addr_o  = mem_req_o ? ({addr_q[ADDR_SIZE-1:OW], {OW{1'b0}}}
                                      + (hi_beat ? ADDR_SIZE'(B) : '0)) : '0;
    assign mem_be_o    = mem_req_o ? (hi_beat ? be_full[2*B-1:B] : be_full[B-1:0]) : '0;
    assign mem_wdata_o = mem_req_o ? (hi_beat ? wdata_full[2*DATA_W-1:DATA_W]
                                              : wdata_full[DATA_W-1:0]) : '0;

    segre_lsu_rdata_ext #(
        .DATA_W (DATA_W)
    ) u_rdata_ext (
        .beat0_i    (beat0_q),
        .beat1_i    (beat1_q),
        .off_i      (off_q),
        .type_i     (type_q),
        .unsigned_i (unsigned_q),
        .rdata_o    (ext_rdata)
    );

    assign in_resp     = !rst_i && (state_q == LSU_RESP);
    assign rsp_valid_o = in_resp;
`ifdef SEGRE_LSU_MISALIGNED_EN
    assign rsp_err_o   = 1'b0;
    assign rsp_rdata_o = (in_resp && !store_q) ? ext_rdata : '0;
`else
    assign rsp_err_o   = in_resp && cross_q;
    assign rsp_rdata_o = (in_resp && !store_q && !cross_q) ? ext_rdata : '0;
`endif

endmodule

// File: doc/segre_lsu.md
# segre_lsu

Parametrised load/store unit between the Segre core's MEM stage and the data memory port. Accepts one BYTE/HALF/WORD access at a time, generates byte enables and lane-shifted write data, and sign- or zero-extends load data. Supports data buses wider than 32 bits. Word-crossing accesses are either split into two bus transactions or rejected, selected at compile time.

## Interface
- DATA_W, 32: memory bus width in bits; power of two, ≥32.
- ADDR_SIZE, 32: address width.
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- req_valid_i  in  1  core request valid.
- req_ready_o  out  1  LSU can accept a request (IDLE only).
- req_store_i  in  1  1 = store, 0 = load.
- req_type_i  in  2  memop_data_type_e (BYTE/HALF/WORD).
- req_unsigned_i  in  1  zero-extend load result.
- req_addr_i  in  ADDR_SIZE  byte address.
- req_wdata_i  in  32  store data, right-aligned.
- rsp_valid_o  out  1  one-cycle completion pulse.
- rsp_rdata_o  out  32  extended load data; 0 for stores.
- rsp_err_o  out  1  rejected access; valid with rsp_valid_o.
- mem_req_o  out  1  bus request.
- mem_we_o  out  1  write enable.
- mem_addr_o  out  ADDR_SIZE  bus-aligned address (low log2(DATA_W/8) bits zero).
- mem_be_o  out  DATA_W/8  byte enables.
- mem_wdata_o  out  DATA_W  lane-shifted write data.
- mem_gnt_i  in  1  address phase accepted.
- mem_rvalid_i  in  1  response for every granted request, loads and stores; earliest the cycle after grant.
- mem_rdata_i  in  DATA_W  read data.

## Operation
- B = DATA_W/8. Access size S = 1, 2 or 4. Offset O = addr mod B.
- Crossing: O + S > B.
- Non-crossing: one access at addr − O.
  - Byte enables: ((1<<S)−1) << O.
  - Write data: req_wdata_i << 8·O.
  - Load data: (mem_rdata_i >> 8·O), truncated to S bytes.
- Crossing access:
  - First beat: bytes O..B−1 at addr − O.
  - Second beat: remaining bytes at addr − O + B, with be starting at lane 0.
  - Load result is the little-endian concatenation of the two beats.
- Extension: sign-extend from bit 8S−1 unless req_unsigned_i; WORD is passed through unchanged.
- Request fields are captured on the handshake cycle; later input changes are ignored.
- FSM:
  - IDLE: on handshake, go to REQ0; if crossing and the feature is off, go to RESP with error set.
  - REQ0: on mem_gnt_i, go to WAIT0.
  - WAIT0: on mem_rvalid_i, go to REQ1 if split, else RESP.
  - REQ1: on mem_gnt_i, go to WAIT1.
  - WAIT1: on mem_rvalid_i, go to RESP.
  - RESP: go to IDLE.
- mem_rvalid_i outside WAIT0/WAIT1 is ignored.

## Timing
- While rst_i is high:
  - All outputs are 0; state is IDLE.
  - req_ready_o is 1 from the first cycle after rst_i falls.
- req_ready_o = (state == IDLE); it is registered-state derived.
- mem_req_o is asserted from the cycle after the handshake.
  - mem_addr_o, mem_be_o, mem_wdata_o and mem_we_o are held stable until mem_gnt_i.
  - mem_req_o deasserts the cycle after grant.
- Latency with zero-wait memory (grant in cycle N+1, rvalid in N+2):
  - Single access: rsp_valid_o in N+3.
  - Split access: rsp_valid_o in N+5.
  - Error: rsp_valid_o in N+1, with no mem_req_o.
- rsp_valid_o is high for exactly one cycle; rsp_rdata_o and rsp_err_o are valid only in that cycle, and 0 otherwise.
- Reset mid-transaction: the FSM returns to IDLE, mem_req_o drops the next cycle, no response is produced, and a late rvalid is ignored.

## Configuration
- SEGRE_LSU_MISALIGNED_EN defined: crossing accesses are split into two beats as above; rsp_err_o is always 0.
- Undefined: crossing accesses complete immediately with rsp_err_o = 1, rsp_rdata_o = 0, and no bus activity. REQ1/WAIT1 logic is compiled out.
- Non-crossing unaligned accesses (e.g. HALF at offset 1) are always supported.

## Structure
- segre_pkg gains lsu_state_e {LSU_IDLE, LSU_REQ0, LSU_WAIT0, LSU_REQ1, LSU_WAIT1, LSU_RESP}.
- segre_pkg gains a function memop_size_bytes(memop_data_type_e).
- The existing memop_data_type_e is reused.
- Sub-module segre_lsu_rdata_ext: combinational beat merge, lane shift and sign/zero extension.

## Test plan
- SW 0xDEADBEEF at 0x100, DATA_W=32, zero-wait memory -> mem_addr 0x100, be 4'b1111, wdata 0xDEADBEEF, we=1; rsp_valid_o 3 cycles after handshake.
- LB 0x103 with mem_rdata 0x80000000 -> rsp_rdata 0xFFFFFF80; same access with unsigned -> 0x00000080.
- SH 0x1234 at 0x101 -> be 4'b0110, wdata 0x00123400, single beat.
- LW at 0x102, beats return 0xAABBCCDD then 0x11223344:
  - With macro: addresses 0x100/0x104, be 4'b1100/4'b0011, result 0x3344AABB.
  - Without macro: rsp_err_o=1 at N+1, no mem_req_o.
- mem_gnt_i held low 3 cycles -> mem_req_o and address fields stable; req_ready_o=0; extra req_valid_i ignored.
- rst_i in WAIT0, then mem_rvalid_i after reset -> no rsp_valid_o; req_ready_o=1 the cycle after rst_i falls.
